// File: rtl/wu_fetch_pipe_pkg.sv
// wu_fetch_pipe_pkg: shared types and default widths for the WU fetch pipe.
// Holds the fetch FSM encoding and parameter defaults.
package wu_fetch_pipe_pkg;

   typedef enum logic [1:0] {
      WF_IDLE  = 2'd0,
      WF_FETCH = 2'd1,
      WF_DRAIN = 2'd2,
      WF_DONE  = 2'd3
   } wf_state_e;

   localparam int WF_ADDR_W     = 24;
   localparam int WF_DATA_W     = 64;
   localparam int WF_RD_LAT     = 1;
   localparam int WF_FIFO_DEPTH = 4;

endpackage

// File: rtl/wu_fetch_pipe_if.sv
// wu_fetch_pipe_if: WU memory read bus and WU decoder handshake.
// master = fetcher side, slave = memory/decoder side.
interface wu_fetch_pipe_if
   import wu_fetch_pipe_pkg::*;
#(
   parameter int ADDR_W = WF_ADDR_W,
   parameter int DATA_W = WF_DATA_W
);

   logic              wuf__wum__read;
   logic [ADDR_W-1:0] wuf__wum__addr;
   logic              wum__wuf__valid;
   logic              wum__wuf__halt;
   logic [DATA_W-1:0] wum__wuf__data;

   logic              wuf__wud__valid;
   logic [DATA_W-1:0] wuf__wud__data;
   logic              wuf__wud__halt;
   logic              wud__wuf__ready;
   logic              wud__wuf__redirect;
   logic [ADDR_W-1:0] wud__wuf__redirect_addr;

   modport master (
      output wuf__wum__read,
      output wuf__wum__addr,
      input  wum__wuf__valid,
      input  wum__wuf__halt,
      input  wum__wuf__data,
      output wuf__wud__valid,
      output wuf__wud__data,
      output wuf__wud__halt,
      input  wud__wuf__ready,
      input  wud__wuf__redirect,
      input  wud__wuf__redirect_addr
   );

   modport slave (
      input  wuf__wum__read,
      input  wuf__wum__addr,
      output wum__wuf__valid,
      output wum__wuf__halt,
      output wum__wuf__data,
      input  wuf__wud__valid,
      input  wuf__wud__data,
      input  wuf__wud__halt,
      output wud__wuf__ready,
      output wud__wuf__redirect,
      output wud__wuf__redirect_addr
   );

endinterface

// File: rtl/wu_fetch_pipe_fifo.sv
// wu_fetch_pipe_fifo: generic sync FIFO with push/pop/flush and occupancy.
// Ports: clk, reset_poweron, push, pop, flush, din, dout (head), count, empty.
module wu_fetch_pipe_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_poweron,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_C);
   assign do_pop  = pop && !empty;
   // A full FIFO can still take a word when the head leaves this cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_poweron || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         assert (!(push && full && !do_pop));
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wu_fetch_pipe.sv
// wu_fetch_pipe: sequential WU prefetcher with credit-checked FIFO, halt
// drain, decoder redirect with in-flight flush and start/done control.
// Ports: clk, reset_poweron, mcntl start/start_addr/enable/busy/done,
// bus (wu_fetch_pipe_if.master: WU memory reads + decoder handshake).
// Macro WU_FETCH_PERF_EN adds wuf__sys__fetch_count / stall_count.
module wu_fetch_pipe
   import wu_fetch_pipe_pkg::*;
#(
   parameter int ADDR_W     = WF_ADDR_W,
   parameter int DATA_W     = WF_DATA_W,
   parameter int RD_LAT     = WF_RD_LAT,
   parameter int FIFO_DEPTH = WF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset_poweron,
   input  logic              mcntl__wuf__start,
   input  logic [ADDR_W-1:0] mcntl__wuf__start_addr,
   input  logic              mcntl__wuf__enable,
   output logic              wuf__mcntl__busy,
   output logic              wuf__mcntl__done,
`ifdef WU_FETCH_PERF_EN
   output logic [31:0]       wuf__sys__fetch_count,
   output logic [31:0]       wuf__sys__stall_count,
`endif
   wu_fetch_pipe_if.master   bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(FIFO_DEPTH);

   wf_state_e         state;
   wf_state_e         state_nx;
   logic [ADDR_W-1:0] pc;
   logic              epoch;
   logic [CNT_W-1:0]  in_flight;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_empty;
   logic [DATA_W-1:0] head_data;
   logic              head_halt;

   // Per-slot return tracking, one bit per cycle of read latency.
   // live: a real read is returning (drives in_flight).
   // keep: the read survived any flush since it was issued.
   logic [RD_LAT-1:0] live_q;
   logic [RD_LAT-1:0] keep_q;
   logic [RD_LAT-1:0] tag_q;

   logic active;
   logic redir;
   logic start_ok;
   logic ret_live;
   logic ret_ok;
   logic push;
   logic halt_push;
   logic kill;
   logic credit_ok;
   logic issue;
   logic pop;

   assign active   = (state == WF_FETCH) || (state == WF_DRAIN);
   assign redir    = bus.wud__wuf__redirect && active;
   assign start_ok = mcntl__wuf__start && (state == WF_IDLE);

   assign ret_live = bus.wum__wuf__valid && live_q[RD_LAT-1]
                     && (in_flight != '0);
   assign ret_ok   = ret_live && keep_q[RD_LAT-1]
                     && (tag_q[RD_LAT-1] == epoch);

   assign push      = ret_ok && !redir && (state == WF_FETCH);
   assign halt_push = push && bus.wum__wuf__halt;
   assign kill      = redir || halt_push;

   assign credit_ok = ({1'b0, in_flight} + {1'b0, fifo_cnt}) < CREDITS;
   assign issue     = (state == WF_FETCH) && mcntl__wuf__enable
                      && credit_ok && !redir && !halt_push;

   assign pop = bus.wuf__wud__valid && bus.wud__wuf__ready;

   wu_fetch_pipe_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .push          (push),
      .pop           (pop),
      .flush         (redir),
      .din           ({bus.wum__wuf__halt, bus.wum__wuf__data}),
      .dout          ({head_halt, head_data}),
      .count         (fifo_cnt),
      .empty         (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         state <= WF_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         WF_IDLE: begin
            if (mcntl__wuf__start) state_nx = WF_FETCH;
         end
         WF_FETCH: begin
            if (redir)          state_nx = WF_FETCH;
            else if (halt_push) state_nx = WF_DRAIN;
         end
         WF_DRAIN: begin
            if (redir) begin
               state_nx = WF_FETCH;
            end else if (fifo_empty && (in_flight == '0)) begin
               state_nx = WF_DONE;
            end
         end
         WF_DONE: begin
            state_nx = WF_IDLE;
         end
         default: state_nx = WF_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         pc        <= '0;
         epoch     <= 1'b0;
         in_flight <= '0;
      end else begin
         if (start_ok) begin
            pc <= mcntl__wuf__start_addr;
         end else if (redir) begin
            pc <= bus.wud__wuf__redirect_addr;
         end else if (issue) begin
            pc <= pc + ADDR_W'(1);
         end
         if (kill) begin
            epoch <= ~epoch;
         end
         in_flight <= in_flight + CNT_W'(issue) - CNT_W'(ret_live);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         live_q <= '0;
         keep_q <= '0;
         tag_q  <= '0;
      end else begin
         live_q[0] <= issue;
         keep_q[0] <= issue;
         tag_q[0]  <= epoch;
         for (int i = 1; i < RD_LAT; i++) begin
            live_q[i] <= live_q[i-1];
            keep_q[i] <= keep_q[i-1] && !kill;
            tag_q[i]  <= tag_q[i-1];
         end
      end
   end

   assign wuf__mcntl__busy = (state != WF_IDLE);
   assign wuf__mcntl__done = (state == WF_DONE);

   assign bus.wuf__wum__read = issue;
   assign bus.wuf__wum__addr = issue ? pc : '0;

   assign bus.wuf__wud__valid = !fifo_empty;
   assign bus.wuf__wud__data  = fifo_empty ? '0 : head_data;
   assign bus.wuf__wud__halt  = !fifo_empty && head_halt;

`ifdef WU_FETCH_PERF_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;
   logic        stall;

   assign stall = (state == WF_FETCH) && mcntl__wuf__enable && !credit_ok;

   always_ff @(posedge clk) begin
      if (reset_poweron || start_ok) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (push && (fetch_cnt_q != '1)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign wuf__sys__fetch_count = fetch_cnt_q;
   assign wuf__sys__stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wu_fetch_pipe.sv
// tb_wu_fetch_pipe: directed bench for wu_fetch_pipe with a
// fixed-latency WU memory model and a decoder-side monitor.
module tb_wu_fetch_pipe;

   localparam int AW    = 24;
   localparam int DW    = 64;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset_poweron;
   logic          start;
   logic [AW-1:0] start_addr;
   logic          enable;
   logic          busy;
   logic          done;
`ifdef WU_FETCH_PERF_EN
   logic [31:0]   fcnt;
   logic [31:0]   scnt;
`endif

   always #5 clk = ~clk;

   wu_fetch_pipe_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   wu_fetch_pipe #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RD_LAT     (LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk                    (clk),
      .reset_poweron          (reset_poweron),
      .mcntl__wuf__start      (start),
      .mcntl__wuf__start_addr (start_addr),
      .mcntl__wuf__enable     (enable),
      .wuf__mcntl__busy       (busy),
      .wuf__mcntl__done       (done),
`ifdef WU_FETCH_PERF_EN
      .wuf__sys__fetch_count  (fcnt),
      .wuf__sys__stall_count  (scnt),
`endif
      .bus                    (bus)
   );

   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return {8'hC0, 32'h0, a};
   endfunction

   int            n_chk = 0;
   int            n_fail = 0;
   int            done_cnt = 0;
   logic [AW-1:0] halt_addr = 24'hFFF000;
   logic [DW-1:0] got[$];
   logic          gh[$];
   logic [AW-1:0] reads[$];

   logic          rd_s = 1'b0;
   logic [AW-1:0] ad_s = '0;
   logic [LAT:1]  mv = '0;
   logic [AW-1:0] ma [LAT:1];

   // Monitor and memory request capture, away from the active edge.
   always @(negedge clk) begin
      rd_s = bus.wuf__wum__read;
      ad_s = bus.wuf__wum__addr;
      if (rd_s) reads.push_back(ad_s);
      if (bus.wuf__wud__valid && bus.wud__wuf__ready) begin
         got.push_back(bus.wuf__wud__data);
         gh.push_back(bus.wuf__wud__halt);
      end
      if (done) done_cnt++;
   end

   // WU memory: data returns exactly LAT cycles after the read.
   always @(posedge clk) begin
      #1;
      for (int i = LAT; i > 1; i--) begin
         mv[i] = mv[i-1];
         ma[i] = ma[i-1];
      end
      mv[1] = rd_s;
      ma[1] = ad_s;
      bus.wum__wuf__valid = mv[LAT];
      bus.wum__wuf__data  = mv[LAT] ? word(ma[LAT]) : '0;
      bus.wum__wuf__halt  = mv[LAT] && (ma[LAT] == halt_addr);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input logic [AW-1:0] a);
      step(1);
      start_addr = a;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic clear_q();
      got.delete();
      gh.delete();
      reads.delete();
   endtask

   task automatic wait_done(input string tag, input int maxc);
      int d0;
      bit seen;
      d0 = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < maxc && !seen; i++) begin
         @(negedge clk);
         #1;
         seen = (done_cnt > d0);
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   task automatic wait_got(input string tag, input int n, input int maxc);
      for (int i = 0; i < maxc && got.size() < n; i++) begin
         @(negedge clk);
         #1;
      end
      chk(tag, 64'(got.size() >= n), 64'd1);
   endtask

   function automatic logic [63:0] gw(input int i);
      return (i < got.size()) ? 64'(got[i]) : '1;
   endfunction

   function automatic logic [63:0] gr(input int i);
      return (i < reads.size()) ? 64'(reads[i]) : '1;
   endfunction

   function automatic logic gf(input int i);
      return (i < gh.size()) ? gh[i] : 1'bx;
   endfunction

   initial begin
      int hcnt;
      int bad;
      bit seen;
      reset_poweron = 1'b1;
      start = 1'b0;
      start_addr = '0;
      enable = 1'b1;
      bus.wud__wuf__ready = 1'b0;
      bus.wud__wuf__redirect = 1'b0;
      bus.wud__wuf__redirect_addr = '0;

      // Reset state
      step(3);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_read", 64'(bus.wuf__wum__read), 64'd0);
      chk("rst_addr", 64'(bus.wuf__wum__addr), 64'd0);
      chk("rst_valid", 64'(bus.wuf__wud__valid), 64'd0);
      chk("rst_data", bus.wuf__wud__data, 64'd0);
      chk("rst_halt", 64'(bus.wuf__wud__halt), 64'd0);
      step(1);
      reset_poweron = 1'b0;

      // 1: basic program 0x10..0x13, halt at 0x13
      halt_addr = 24'h000013;
      bus.wud__wuf__ready = 1'b1;
      clear_q();
      done_cnt = 0;
      pulse_start(24'h000010);
      @(negedge clk);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_read0", 64'(bus.wuf__wum__read), 64'd1);
      chk("t1_addr0", 64'(bus.wuf__wum__addr), 64'h10);
      wait_done("t1_done_seen", 200);
      step(3);
      chk("t1_done_once", 64'(done_cnt), 64'd1);
      chk("t1_busy_low", 64'(busy), 64'd0);
      chk("t1_nwords", 64'(got.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_word%0d", i), gw(i),
             word(24'h10 + 24'(i)));
         chk($sformatf("t1_read%0d", i), gr(i), 64'h10 + 64'(i));
      end
      chk("t1_halt_last", 64'(gf(3)), 64'd1);
      chk("t1_halt_first", 64'(gf(0)), 64'd0);

      // 2: back-pressure, then release
      halt_addr = 24'hFFF000;
      bus.wud__wuf__ready = 1'b0;
      clear_q();
      pulse_start(24'h000040);
      step(22);
      @(negedge clk);
      chk("t2_nreads", 64'(reads.size()), 64'd4);
      chk("t2_valid", 64'(bus.wuf__wud__valid), 64'd1);
      chk("t2_head", bus.wuf__wud__data, word(24'h40));
`ifdef WU_FETCH_PERF_EN
      chk("t2_stall_ge15", 64'(scnt >= 32'd15), 64'd1);
      chk("t2_fetch_cnt", 64'(fcnt), 64'd4);
`endif
      step(1);
      bus.wud__wuf__ready = 1'b1;
      pulse_start(24'h000999);
      wait_got("t2_resume", 8, 200);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t2_word%0d", i), gw(i),
             word(24'h40 + 24'(i)));
      end

      // 3: redirect with reads in flight
      step(1);
      bus.wud__wuf__redirect = 1'b1;
      bus.wud__wuf__redirect_addr = 24'h000200;
      @(negedge clk);
      #1;
      chk("t3_no_read", 64'(bus.wuf__wum__read), 64'd0);
      clear_q();
      step(1);
      bus.wud__wuf__redirect = 1'b0;
      wait_got("t3_got3", 3, 200);
      chk("t3_read0", gr(0), 64'h200);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t3_word%0d", i), gw(i),
             word(24'h200 + 24'(i)));
      end

      // stop the stream: redirect straight onto a halt word
      halt_addr = 24'h000300;
      step(1);
      bus.wud__wuf__redirect = 1'b1;
      bus.wud__wuf__redirect_addr = 24'h000300;
      step(1);
      bus.wud__wuf__redirect = 1'b0;
      wait_done("t3_stop_done", 200);
      step(2);
      chk("t3_idle", 64'(busy), 64'd0);

      // 4: PC wrap
      halt_addr = 24'h000001;
      clear_q();
      pulse_start(24'hFFFFFE);
      wait_done("t4_done", 200);
      chk("t4_read0", gr(0), 64'hFFFFFE);
      chk("t4_read1", gr(1), 64'hFFFFFF);
      chk("t4_read2", gr(2), 64'h000000);
      chk("t4_word2", gw(2), word(24'h000000));
      chk("t4_word3", gw(3), word(24'h000001));
      chk("t4_halt3", 64'(gf(3)), 64'd1);

      // 5: redirect in the same cycle as the halt return
      halt_addr = 24'h000403;
      clear_q();
      pulse_start(24'h000400);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         #1;
         seen = bus.wum__wuf__valid && bus.wum__wuf__halt;
      end
      chk("t5_halt_ret", 64'(seen), 64'd1);
      bus.wud__wuf__redirect = 1'b1;
      bus.wud__wuf__redirect_addr = 24'h000500;
      halt_addr = 24'h000502;
      reads.delete();
      step(1);
      bus.wud__wuf__redirect = 1'b0;
      @(negedge clk);
      chk("t5_busy", 64'(busy), 64'd1);
      wait_done("t5_done", 200);
      hcnt = 0;
      bad = 0;
      foreach (gh[i]) if (gh[i]) hcnt++;
      foreach (got[i]) if (got[i] == word(24'h403)) bad++;
      chk("t5_read0", gr(0), 64'h500);
      chk("t5_halts", 64'(hcnt), 64'd1);
      chk("t5_no403", 64'(bad), 64'd0);
      chk("t5_last", gw(got.size() - 1), word(24'h502));

      // 6: reset mid-fetch with returns still in flight
      halt_addr = 24'hFFF000;
      bus.wud__wuf__ready = 1'b0;
      clear_q();
      pulse_start(24'h000600);
      step(1);
      reset_poweron = 1'b1;
      step(1);
      reset_poweron = 1'b0;
      @(negedge clk);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_read", 64'(bus.wuf__wum__read), 64'd0);
      chk("t6_valid", 64'(bus.wuf__wud__valid), 64'd0);
      chk("t6_data", bus.wuf__wud__data, 64'd0);
      step(6);
      @(negedge clk);
      chk("t6_late_valid", 64'(bus.wuf__wud__valid), 64'd0);
      chk("t6_late_busy", 64'(busy), 64'd0);
      halt_addr = 24'h000700;
      bus.wud__wuf__ready = 1'b1;
      got.delete();
      gh.delete();
      pulse_start(24'h000700);
      wait_done("t6_restart_done", 200);
      chk("t6_restart_n", 64'(got.size()), 64'd1);
      chk("t6_restart_w", gw(0), word(24'h700));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
